// File: rtl/dawson64_pkg.sv
// dawson64_pkg: shared state encoding and constants for the Dawson 64-bit responder
package dawson64_pkg;
  localparam int DAWSON_W = 64;
  localparam logic [DAWSON_W-1:0] DAWSON_QNAN = 64'h7FF8000000000000;
  typedef enum logic [1:0] {GET_OPS, ISSUE, WAIT_RES, PUT_Z} state_t;
endpackage

// File: rtl/dawson64_timeout_ctr.sv
// dawson64_timeout_ctr: counts enabled cycles and flags the cycle that reaches the limit
module dawson64_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [W-1:0] LAST = TIMEOUT_CYCLES > 0 ? W'(TIMEOUT_CYCLES - 1) : '0;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tc_o = (TIMEOUT_CYCLES > 0) && en_i && cnt_q == LAST;
    cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/dawson64_responder.sv
// dawson64_responder: Dawson stb/ack responder driving a ready_in/ready_out execution unit
module dawson64_responder
  import dawson64_pkg::*;
#(
  parameter int WIDTH = DAWSON_W,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [WIDTH-1:0] TIMEOUT_Z = WIDTH'(DAWSON_QNAN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  input  logic [WIDTH-1:0] input_b,
  input  logic             input_b_stb,
  output logic             input_b_ack,
  output logic [WIDTH-1:0] output_z,
  output logic             output_z_stb,
  input  logic             output_z_ack,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             ready_in,
  input  logic [WIDTH-1:0] out,
  input  logic             ready_out,
  output logic             timeout_err,
  output logic [7:0]       spurious_cnt
);
  state_t state_q, state_d;
  logic got_a_q, got_a_d, got_b_q, got_b_d;
  logic a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic err_q, err_d, a_xfer, b_xfer, tc;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic [7:0] spur_q, spur_d;
  dawson64_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk(clk),
    .rst(rst),
    .clr_i(state_q == ISSUE),
    .en_i(state_q == WAIT_RES),
    .tc_o(tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= GET_OPS;
      got_a_q <= 1'b0;
      got_b_q <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      err_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      z_q <= '0;
      spur_q <= '0;
    end else begin
      state_q <= state_d;
      got_a_q <= got_a_d;
      got_b_q <= got_b_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      err_q <= err_d;
      a_q <= a_d;
      b_q <= b_d;
      z_q <= z_d;
      spur_q <= spur_d;
    end
  always_comb begin
    a_xfer = input_a_stb && a_ack_q;
    b_xfer = input_b_stb && b_ack_q;
    got_a_d = state_q == ISSUE ? 1'b0 : got_a_q | a_xfer;
    got_b_d = state_q == ISSUE ? 1'b0 : got_b_q | b_xfer;
    a_d = a_xfer ? input_a : a_q;
    b_d = b_xfer ? input_b : b_q;
    state_d = state_q;
    z_d = z_q;
    err_d = err_q;
    case (state_q)
      GET_OPS:  if (got_a_d && got_b_d) state_d = ISSUE;
      ISSUE:    state_d = WAIT_RES;
      // a result arriving on the terminal-count edge beats the timeout
      WAIT_RES: if (ready_out) begin
        z_d = out;
        state_d = PUT_Z;
      end else if (tc) begin
        z_d = TIMEOUT_Z;
        err_d = 1'b1;
        state_d = PUT_Z;
      end
      PUT_Z:    if (output_z_ack) state_d = GET_OPS;
      default:  state_d = GET_OPS;
    endcase
    a_ack_d = state_d == GET_OPS && !got_a_d;
    b_ack_d = state_d == GET_OPS && !got_b_d;
    spur_d = (ready_out && state_q != WAIT_RES && spur_q != 8'hFF) ? spur_q + 8'd1 : spur_q;
  end
  always_comb begin
    input_a_ack = a_ack_q;
    input_b_ack = b_ack_q;
    ready_in = state_q == ISSUE;
    output_z_stb = state_q == PUT_Z;
    output_z = z_q;
    a = a_q;
    b = b_q;
    timeout_err = err_q;
    spurious_cnt = spur_q;
  end
endmodule

// File: doc/dawson64_responder.md
Name: dawson64_responder

Overview:
- Responder (slave) end of the 64-bit Dawson stb/ack operand/result protocol.
- Accepts operands input_a and input_b over independent stb/ack channels and launches one operation on a user-style execution unit (single-cycle ready_in pulse, ready_out completion pulse).
- Returns the result on output_z with an output_z_stb/output_z_ack handshake.
- Lets any user-interface double-precision unit be dropped in wherever a Dawson-protocol unit is expected. Adds a completion timeout and error reporting.

Parameters:
- WIDTH, 64, operand/result width in bits.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT_RES before abort; 0 disables the timeout.
- TIMEOUT_Z, 64'h7FF8000000000000, value returned on output_z after a timeout (quiet NaN).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- input_a  input  WIDTH  operand A from initiator.
- input_a_stb  input  1  initiator offers A.
- input_a_ack  output  1  responder can take A; transfer when stb && ack at posedge.
- input_b  input  WIDTH  operand B from initiator.
- input_b_stb  input  1  initiator offers B.
- input_b_ack  output  1  responder can take B; transfer when stb && ack at posedge.
- output_z  output  WIDTH  result to initiator.
- output_z_stb  output  1  result valid.
- output_z_ack  input  1  initiator takes result; transfer when stb && ack at posedge.
- a  output  WIDTH  operand A to execution unit (registered).
- b  output  WIDTH  operand B to execution unit (registered).
- ready_in  output  1  one-cycle launch pulse to execution unit.
- out  input  WIDTH  execution unit result.
- ready_out  input  1  execution unit result valid (one-cycle pulse).
- timeout_err  output  1  sticky; set on timeout, cleared only by rst.
- spurious_cnt  output  8  count of ready_out pulses outside WAIT_RES; saturates at 255.

Behaviour:
- Reset (async, immediate):
  - All outputs 0: acks, output_z_stb, ready_in, a, b, output_z, timeout_err, spurious_cnt.
  - State = GET_OPS; got_a = got_b = 0; timeout counter = 0.
  - Reset mid-operation discards captured operands and any in-flight result.
  - A late ready_out after reset counts as spurious.
- States: GET_OPS -> ISSUE -> WAIT_RES -> PUT_Z -> GET_OPS.
- GET_OPS:
  - input_a_ack = !got_a and input_b_ack = !got_b, registered; the first ack rises the cycle after reset deasserts.
  - On A transfer: a <= input_a, got_a <= 1, input_a_ack drops the next cycle. B is handled identically.
  - A and B may arrive in either order or in the same cycle.
  - When both are captured (including same-cycle capture of the last one), go to ISSUE on the following edge.
- ISSUE (exactly 1 cycle):
  - ready_in = 1; a and b stable; both acks 0.
  - Next state WAIT_RES; clear got_a, got_b and the timeout counter.
- WAIT_RES:
  - ready_in = 0; a and b held stable until leaving the state.
  - On ready_out sampled high: output_z <= out, output_z_stb <= 1 next cycle, go to PUT_Z.
  - Execution unit minimum latency is 1 cycle; ready_out during the ISSUE cycle counts as spurious.
  - Timeout (TIMEOUT_CYCLES > 0): the counter increments each WAIT_RES cycle. When it reaches TIMEOUT_CYCLES with no ready_out: output_z <= TIMEOUT_Z, timeout_err <= 1, go to PUT_Z.
  - ready_out on the same edge the counter reaches the limit: the result wins and there is no error.
- PUT_Z:
  - output_z_stb held high and output_z stable until output_z_ack.
  - On transfer, output_z_stb drops the next cycle, state becomes GET_OPS, and acks re-assert that same cycle.
  - output_z itself holds its last value.
- Operand stb asserted outside GET_OPS: ignored (ack is 0); the initiator keeps stb high.
- ready_out outside WAIT_RES: spurious_cnt += 1 (saturating); no other effect.
- Minimum round trip, ack-ack:
  - Operands captured at edge N: ready_in high in cycle N+1.
  - ready_out at edge M: output_z_stb high from M+1.

Decomposition:
- Package dawson64_pkg:
  - state enum (GET_OPS, ISSUE, WAIT_RES, PUT_Z);
  - DAWSON_QNAN constant;
  - operand width localparam.
- One natural sub-module: dawson64_timeout_ctr (clear, enable, terminal-count flag; parameter TIMEOUT_CYCLES). The rest is flat.

Test Plan:
- Bench setup: behavioural execution unit that computes a + b over 3 cycles, plus a Dawson initiator model.
- A then B, 2 cycles apart: A = 64'h3FF3AE147AE147AE, B = 64'h40123D70A3D70A3D -> one ready_in pulse; output_z = 64'h401728F5C28F5C28, output_z_stb held until ack.
- Same-cycle A/B: A = 64'h409ED5ECFBFC6541, B = 64'h40C201336E2EB1C4; output_z_ack delayed 5 cycles -> output_z = 64'h40C5DBF10DAE3E6C stable for all 5 cycles; acks return 1 cycle after the z transfer.
- B before A with a negative operand: A = 64'h40E7FF26B851EB85, B = 64'hC0DBBC53851EB852 -> output_z = 64'h40D441F9EB851EB8.
- Unit never responds, TIMEOUT_CYCLES = 16 -> output_z_stb rises 17 cycles after ready_in; output_z = 64'h7FF8000000000000; timeout_err = 1 and stays 1 through the next good transaction.
- Spurious and reset:
  - ready_out pulsed 3 times in GET_OPS -> spurious_cnt = 3.
  - rst asserted in WAIT_RES -> all outputs 0 immediately.
  - The late ready_out that follows -> spurious_cnt = 1 and no output_z_stb.
